// File: rtl/ddram_loader_pkg.sv
// Shared types for the ioctl-to-DDR word loader: FSM states, FIFO entry layout
// and the DDR byte-address width.
package ddram_loader_pkg;

    localparam int DDR_ADDR_W = 28;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DDR_ADDR_W-1:0] addr;
        logic [15:0]           data;
    } fifo_entry_t;

endpackage

// File: rtl/ddram_loader_fifo.sv
// Small synchronous FIFO of address/data entries; push on full and pop on
// empty are ignored, so callers need not gate them.
module ddram_loader_fifo
    import ddram_loader_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  fifo_entry_t       din,
    output fifo_entry_t       dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fifo_entry_t      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/ddram_loader.sv
// Buffers HPS ioctl download words and drains them into the DDR port through
// the we_req/we_ack toggle handshake, with back-pressure and completion pulse.
module ddram_loader
    import ddram_loader_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 8,
    parameter logic [DDR_ADDR_W-1:0] BASE       = 28'h0000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [15:0]           ioctl_dout,
    output logic                  ioctl_wait,
    output logic [DDR_ADDR_W-1:0] wraddr,
    output logic [15:0]           din,
    output logic                  we_req,
    input  logic                  we_ack,
    output logic                  done,
    output logic                  overflow,
    output logic                  misalign,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_LVL = FIFO_DEPTH - 2;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we_req;
    logic [DDR_ADDR_W-1:0] r_wraddr;
    logic [15:0]           r_din;
    logic                  r_wait;
    logic                  r_dl_prev;
    logic                  r_pend;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_misalign;

    logic                  w_strobe;
    logic                  w_push;
    logic                  w_ovf;
    logic                  w_mis;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_acked;
    logic                  w_issue;
    fifo_entry_t           w_entry;
    fifo_entry_t           w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;

    assign w_strobe = ioctl_wr && ioctl_download;
    assign w_push   = w_strobe && !ioctl_addr[0] && !w_full;
    assign w_ovf    = w_strobe && !ioctl_addr[0] && w_full;
    assign w_mis    = w_strobe && ioctl_addr[0];
    assign w_rise   = ioctl_download && !r_dl_prev;
    assign w_fall   = !ioctl_download && r_dl_prev;
    assign w_acked  = (we_ack == r_we_req);

    always_comb begin
        w_entry.addr = BASE + {{(DDR_ADDR_W-25){1'b0}}, ioctl_addr};
        w_entry.data = ioctl_dout;
    end

    ddram_loader_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_issue),
        .din   (w_entry),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= SYNC;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            SYNC: w_next = IDLE;
            IDLE: begin
                if (!w_empty && w_acked) begin
                    w_issue = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (w_acked) begin
                    if (!w_empty) w_issue = 1'b1;
                    else          w_next  = IDLE;
                end
            end
            default: w_next = SYNC;
        endcase
    end

    // SYNC adopts the port's acknowledge level so the first toggle is real.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_we_req <= 1'b0;
            r_wraddr <= '0;
            r_din    <= '0;
        end else if (r_state == SYNC) begin
            r_we_req <= we_ack;
        end else if (w_issue) begin
            r_we_req <= ~r_we_req;
            r_wraddr <= w_head.addr;
            r_din    <= w_head.data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wait     <= 1'b0;
            r_dl_prev  <= 1'b0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_wait    <= (w_count >= CNT_W'(WAIT_LVL));
            r_dl_prev <= ioctl_download;
            r_done    <= 1'b0;
            if (w_rise) begin
                r_pend <= 1'b0;
            end else if (w_fall) begin
                r_pend <= 1'b1;
            end else if (r_pend && w_empty && w_acked) begin
                r_pend <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_ovf)       r_overflow <= 1'b1;
            else if (w_rise) r_overflow <= 1'b0;
            if (w_mis)       r_misalign <= 1'b1;
            else if (w_rise) r_misalign <= 1'b0;
        end
    end

    assign ioctl_wait = r_wait;
    assign wraddr     = r_wraddr;
    assign din        = r_din;
    assign we_req     = r_we_req;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign misalign   = r_misalign;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ddram_loader.sv
// Bench for ddram_loader: toggle-handshake DDR port model with adjustable ack
// delay, and a scoreboard of expected {wraddr, din} requests in issue order.
module tb_ddram_loader;
    import ddram_loader_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [27:0] BASE = 28'hFF00000;

    logic        clk_sys        = 1'b0;
    logic        reset          = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [15:0] ioctl_dout     = '0;
    logic        ioctl_wait;
    logic [27:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack         = 1'b0;
    logic        done;
    logic        overflow;
    logic        misalign;
    logic [1:0]  dbg_state;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_req      = 0;
    bit          ack_stall  = 1'b0;
    int          ack_delay  = 3;
    int          ack_cnt    = 0;
    bit          mon_ignore = 1'b0;
    logic        prev_req   = 1'b0;
    logic [43:0] exp_q[$];

    ddram_loader #(.FIFO_DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .wraddr         (wraddr),
        .din            (din),
        .we_req         (we_req),
        .we_ack         (we_ack),
        .done           (done),
        .overflow       (overflow),
        .misalign       (misalign),
        .dbg_state      (dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    // DDR port: returns the request toggle ack_delay cycles after seeing it.
    always @(posedge clk_sys) begin
        if (!ack_stall && we_req !== we_ack) begin
            if (ack_cnt >= ack_delay - 1) begin
                we_ack  <= we_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    // Scoreboard: every toggle of we_req is one request, checked in order.
    always @(negedge clk_sys) begin
        logic [43:0] exp;
        if (reset || mon_ignore) begin
            prev_req = we_req;
        end else if (we_req !== prev_req) begin
            prev_req = we_req;
            n_req++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL req_unexpected: got addr=%h data=%h, required no request", wraddr, din);
            end else begin
                exp = exp_q.pop_front();
                if ({wraddr, din} !== exp) begin
                    n_errors++;
                    $display("FAIL req_content: got addr=%h data=%h, required addr=%h data=%h",
                             wraddr, din, exp[43:16], exp[15:0]);
                end
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Caller is just after a rising edge; the strobe covers exactly one cycle.
    task automatic drive_word(input logic [24:0] a, input logic [15:0] d, input bit accept);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (accept) exp_q.push_back({BASE + {3'b000, a}, d});
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || we_req !== we_ack) && cyc < 1000) begin
            go(1);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0 || we_req !== we_ack) begin
            n_errors++;
            $display("FAIL %s_drain: %0d words still expected, we_req=%b we_ack=%b, required 0 and equal",
                     name, exp_q.size(), we_req, we_ack);
        end
    endtask

    task automatic wait_req(input int old, input string name);
        int cyc = 0;
        while (n_req == old && cyc < 50) begin
            go(1);
            cyc++;
        end
        n_checks++;
        if (n_req == old) begin
            n_errors++;
            $display("FAIL %s_issue: got %0d requests, required %0d", name, n_req, old + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        n_checks++;
        if ({we_req, ioctl_wait, done, overflow, misalign} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got req/wait/done/ovf/mis=%b, required 00000",
                     {we_req, ioctl_wait, done, overflow, misalign});
        end
        n_checks++;
        if (wraddr !== 28'h0 || din !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_data: got wraddr=%h din=%h, required 0 0", wraddr, din);
        end
        n_checks++;
        if (dbg_state !== 2'(SYNC)) begin
            n_errors++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, 2'(SYNC));
        end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        n_checks++;
        if (dbg_state !== 2'(IDLE)) begin
            n_errors++;
            $display("FAIL reset_to_idle: got %0d, required %0d", dbg_state, 2'(IDLE));
        end
    endtask

    task automatic test_single_word();
        logic r0;
        int   base;
        int   dn = 0;
        ack_delay      = 3;
        ioctl_download = 1'b1;
        go(2);
        r0   = we_req;
        base = n_req;
        drive_word(25'h000010, 16'hBEEF, 1'b1);
        @(negedge clk_sys);
        n_checks++;
        if (we_req !== r0) begin
            n_errors++;
            $display("FAIL single_lat_n1: got we_req=%b, required %b", we_req, r0);
        end
        @(negedge clk_sys);
        n_checks++;
        if (we_req !== ~r0) begin
            n_errors++;
            $display("FAIL single_lat_n2: got we_req=%b, required %b", we_req, ~r0);
        end
        wait_idle("single");
        n_checks++;
        if (n_req != base + 1) begin
            n_errors++;
            $display("FAIL single_count: got %0d requests, required %0d", n_req - base, 1);
        end
        ioctl_download = 1'b0;
        repeat (10) begin
            @(negedge clk_sys);
            if (done === 1'b1) dn++;
        end
        n_checks++;
        if (dn != 1) begin
            n_errors++;
            $display("FAIL single_done: got %0d done cycles, required 1", dn);
        end
    endtask

    task automatic test_burst_slow_ack();
        int  sent = 0;
        int  pushes = 0;
        int  cyc = 0;
        int  base;
        int  lvl = -1;
        logic [24:0] a;
        ack_delay      = 10;
        ioctl_download = 1'b1;
        go(2);
        base = n_req;
        while (sent < 12 && cyc < 2000) begin
            if (ioctl_wait === 1'b1 && lvl < 0) lvl = pushes - (n_req - base);
            if (ioctl_wait === 1'b0) begin
                a = (sent == 5) ? 25'h1FFFFFE : 25'h000100 + 25'(2 * sent);
                ioctl_addr = a;
                ioctl_dout = 16'($urandom_range(0, 65535));
                ioctl_wr   = 1'b1;
                exp_q.push_back({BASE + {3'b000, a}, ioctl_dout});
                sent++;
                pushes++;
            end else begin
                ioctl_wr = 1'b0;
            end
            go(1);
            cyc++;
        end
        ioctl_wr = 1'b0;
        n_checks++;
        if (sent != 12) begin
            n_errors++;
            $display("FAIL burst_sent: got %0d words accepted by HPS, required 12", sent);
        end
        n_checks++;
        if (lvl != DEPTH - 1) begin
            n_errors++;
            $display("FAIL burst_wait_level: got fill %0d when wait seen, required %0d", lvl, DEPTH - 1);
        end
        wait_idle("burst");
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL burst_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_overflow();
        int base;
        ack_delay = 2;
        ack_stall = 1'b1;
        base      = n_req;
        drive_word(25'h000200, 16'hA000, 1'b1);
        wait_req(base, "ovf_first");
        for (int i = 0; i < 9; i++)
            drive_word(25'h000202 + 25'(2 * i), 16'hA001 + 16'(i), i < 8);
        @(negedge clk_sys);
        n_checks++;
        if (overflow !== 1'b1 || ioctl_wait !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_flag: got overflow=%b wait=%b, required 1 1", overflow, ioctl_wait);
        end
        base      = n_req;
        ack_stall = 1'b0;
        wait_idle("ovf");
        n_checks++;
        if (n_req - base != 8) begin
            n_errors++;
            $display("FAIL ovf_count: got %0d requests after resume, required 8", n_req - base);
        end
    endtask

    task automatic test_misalign();
        int base;
        ioctl_download = 1'b0;
        go(1);
        ioctl_download = 1'b1;
        go(1);
        @(negedge clk_sys);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL new_dl_clear: got overflow=%b, required 0", overflow);
        end
        go(1);
        base = n_req;
        drive_word(25'h000003, 16'h1234, 1'b0);
        go(6);
        n_checks++;
        if (misalign !== 1'b1 || n_req != base) begin
            n_errors++;
            $display("FAIL mis_flag: got misalign=%b requests=%0d, required 1 0", misalign, n_req - base);
        end
        drive_word(25'h000040, 16'h5678, 1'b1);
        wait_idle("mis");
        n_checks++;
        if (n_req != base + 1) begin
            n_errors++;
            $display("FAIL mis_follow: got %0d requests, required 1", n_req - base);
        end
    endtask

    task automatic test_done_delay();
        int base;
        int dn = 0;
        bit early = 1'b0;
        ack_delay = 10;
        go(1);
        base = n_req;
        for (int i = 0; i < 3; i++)
            drive_word(25'h000300 + 25'(2 * i), 16'($urandom_range(0, 65535)), 1'b1);
        ioctl_download = 1'b0;
        repeat (120) begin
            @(negedge clk_sys);
            if (done === 1'b1) begin
                dn++;
                if (n_req != base + 3 || we_req !== we_ack) early = 1'b1;
            end
        end
        n_checks++;
        if (dn != 1 || early) begin
            n_errors++;
            $display("FAIL done_delay: got %0d pulses early=%b, required 1 pulse after last ack", dn, early);
        end
        wait_idle("done");
        ioctl_download = 1'b1;
        go(2);
        ioctl_download = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk_sys);
            if (done === 1'b1) dn++;
        end
        n_checks++;
        if (dn != 1) begin
            n_errors++;
            $display("FAIL done_short: got %0d pulses for empty download, required 1", dn);
        end
    endtask

    task automatic test_reset_outstanding();
        int   base;
        int   chg = 0;
        logic r;
        ack_delay      = 3;
        ioctl_download = 1'b1;
        go(2);
        if (we_ack === 1'b0) begin
            drive_word(25'h000400, 16'h0F0F, 1'b1);
            wait_idle("rst_pre");
        end
        ack_stall = 1'b1;
        base      = n_req;
        drive_word(25'h000402, 16'hF0F0, 1'b1);
        wait_req(base, "rst_out");
        n_checks++;
        if (we_req === we_ack) begin
            n_errors++;
            $display("FAIL rst_pending: got we_req=%b we_ack=%b, required unequal", we_req, we_ack);
        end
        mon_ignore = 1'b1;
        @(posedge clk_sys);
        #3;
        reset = 1'b1;
        @(negedge clk_sys);
        n_checks++;
        if ({we_req, ioctl_wait, done, overflow, misalign} !== 5'b0 || wraddr !== 28'h0 || din !== 16'h0) begin
            n_errors++;
            $display("FAIL rst_outputs: got flags=%b wraddr=%h din=%h, required all 0",
                     {we_req, ioctl_wait, done, overflow, misalign}, wraddr, din);
        end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        n_checks++;
        if (we_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_sync: got we_req=%b, required copy of we_ack 1", we_req);
        end
        r = we_req;
        repeat (8) begin
            @(negedge clk_sys);
            if (we_req !== r) chg++;
        end
        n_checks++;
        if (chg != 0) begin
            n_errors++;
            $display("FAIL rst_no_toggle: got %0d toggles, required 0", chg);
        end
        mon_ignore = 1'b0;
        ack_stall  = 1'b0;
        go(1);
        drive_word(25'h000500, 16'hC0DE, 1'b1);
        wait_idle("rst_after");
        n_checks++;
        if (n_req != base + 2) begin
            n_errors++;
            $display("FAIL rst_resume: got %0d requests, required %0d", n_req - base, 2);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst_slow_ack();
        test_overflow();
        test_misalign();
        test_done_delay();
        test_reset_outstanding();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover: got %0d unmatched words, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
